instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front end of the 16-bit simplified MIPS core. Owns the program counter, reads the combinational instruction memory at byte address PC, and buffers fetched words in a small prefetch queue. Decode/execute consumes the words through a valid/ready handshake. Provides a PC redirect for branches and jumps, and stops fetching at the halt word.

## Interface
Parameters:
- DEPTH, 2: queue entries; power of two, 2..8.
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- IMemAddress  out  16  byte address to instruction memory; equals FetchPC.
- IMemData  in  16  instruction word, valid in the same cycle as IMemAddress.
- Redirect  in  1  load a new fetch PC and flush the queue.
- RedirectPC  in  16  target byte address; bit 0 is ignored (forced 0).
- IR  out  16  head instruction.
- IRPC  out  16  byte address of the head instruction.
- IRValid  out  1  head entry is valid.
- IRReady  in  1  consumer accepts the head entry this cycle.
- Halted  out  1  halt word has been consumed; fetch is stopped.

## Operation
- State: FetchPC (16b), queue (DEPTH × {instr[15:0], pc[15:0]}), count (0..DEPTH), fetch FSM.
- Pop: IRValid && IRReady. Head advances, count decrements.
- Push: occurs when the FSM is RUN, Redirect=0, and either count<DEPTH or a pop happens in the same cycle. The pushed entry is {IMemData, FetchPC}, and FetchPC then increments by 2 (modulo 2^16, so 16'hFFFE wraps to 16'h0000).
- Full with simultaneous pop: push and pop both occur, and count is unchanged.
- Empty: IRValid=0. IR and IRPC hold their last values; the consumer must not use them.
- Redirect priority is Redirect > push/pop. In the Redirect cycle:
  - The queue is flushed (count=0).
  - FetchPC ← {RedirectPC[15:1],1'b0}.
  - The FSM goes to RUN.
  - No push occurs.
  - A handshake in that cycle still counts as consumed by the consumer.
- FSM (with the halt feature):
  - RUN → DRAIN: when the pushed word equals 16'hFFFF. That word is queued, and fetch stops.
  - DRAIN → HALTED: when the halt entry is popped.
  - HALTED: no push. Halted=1.
  - Redirect from any state → RUN.
- resetn=0 at a rising edge sets count=0, FetchPC=RESET_PC, FSM=RUN. This overrides Redirect and handshakes, including mid-drain and a full queue.

## Timing
- Reset values: IRValid=0, Halted=0, IMemAddress=RESET_PC, IR=0, IRPC=0.
- Fetch-to-valid latency is 1 cycle. A word pushed at edge N is visible on IR at edge N+1 with IRValid=1.
- Redirect asserted at edge N:
  - IRValid=0 after N.
  - Target word valid after N+1.
  - Redirect bubble is 1 cycle.
- With IRReady held at 1 and no redirect, throughput is 1 instruction/cycle.
- Halted rises after the edge where the halt entry is popped.
- IR, IRPC and IRValid are register/queue outputs with no combinational path from IRReady. IMemAddress is a registered value.

## Configuration
- FETCH_HALT_DETECT_EN defined: the RUN/DRAIN/HALTED FSM is implemented as above.
- FETCH_HALT_DETECT_EN undefined:
  - 16'hFFFF is an ordinary word.
  - The FSM is permanently RUN.
  - Fetch continues, and FetchPC wraps.
  - Halted is tied to 0.

## Structure
- The shared package holds:
  - INSTR_W=16 and PC_INC=16'd2.
  - HALT_WORD=16'hFFFF.
  - fetch_state_t enum {RUN, DRAIN, HALTED}.
  - fetch_entry_t struct {instr, pc}.
- Sub-module fetch_queue: circular FIFO of fetch_entry_t.
  - Parameter DEPTH; read/write pointers wrap at DEPTH; explicit count.
  - Inputs push, pop and flush; outputs head, empty and full.
- The top level holds FetchPC, the FSM and the redirect priority.

## Test plan
- Reset then stream, with IRReady=1 and memory preloaded 0x710F, 0x7207, …: IRValid rises 1 cycle after resetn goes high. IRPC sequence is 0,2,4,…, with one instruction per cycle and IR matching memory.
- Backpressure, DEPTH=2 with IRReady=0 for 5 cycles: count saturates at 2 and IMemAddress holds at 4. When IRReady=1, entries at PC 0,2,4 appear in order with no loss or duplicates.
- Redirect to 16'h0021 while the queue is full: next IRValid=0. The following cycle gives IRPC=16'h0020 and IR=mem[0x10]. No stale entries appear.
- Halt, with the macro defined and mem[9]=16'hFFFF: IMemAddress stops at 0x12. IR=16'hFFFF is delivered with IRPC=0x12, and Halted=1 after it is popped. A later Redirect to 0 clears Halted and resumes fetch.
- Wrap and no-halt, with the macro undefined: start with Redirect to 16'hFFFC. IRPC sequence is FFFC, FFFE, 0000. A 16'hFFFF word passes through, and Halted stays 0.
- Reset mid-drain: resetn=0 for 1 cycle while in DRAIN with count=2. The next cycle has IRValid=0, Halted=0 and IMemAddress=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// FETCH_HALT_DETECT_EN enables the halt-word fetch FSM.
package instruction_fetch_unit_pkg;

    localparam int          INSTR_W   = 16;
    localparam logic [15:0] PC_INC    = 16'd2;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [15:0]        pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular prefetch FIFO of fetched {instr, pc} entries.
// Flush empties the queue; the caller never pushes when full without a pop.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, redirect priority, halt FSM and prefetch queue.
// FETCH_HALT_DETECT_EN enables stopping fetch at the halt word.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [15:0] IMemAddress,
    input  logic [15:0] IMemData,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC,
    output logic [15:0] IR,
    output logic [15:0] IRPC,
    output logic        IRValid,
    input  logic        IRReady,
    output logic        Halted
);

    logic [15:0]  fetch_pc;
    fetch_state_t state;
    fetch_entry_t head;
    fetch_entry_t last_q;
    logic         empty;
    logic         full;
    logic         pop;
    logic         push;
    logic         halt_push;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = RedirectPC[0];

    assign IMemAddress = fetch_pc;
    assign IRValid     = !empty;
    assign pop         = IRValid && IRReady;
    assign push        = (state == RUN) && !Redirect && (!full || pop);

    // An empty queue shows the last delivered entry rather than a stale slot.
    assign IR   = empty ? last_q.instr : head.instr;
    assign IRPC = empty ? last_q.pc    : head.pc;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .flush  (Redirect),
        .wdata  ('{instr: IMemData, pc: fetch_pc}),
        .head   (head),
        .empty  (empty),
        .full   (full)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_q <= '0;
        end else if (!empty) begin
            last_q <= head;
        end
    end

    // The halt push leaves the PC parked on the halt word.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
        end else if (Redirect) begin
            fetch_pc <= {RedirectPC[15:1], 1'b0};
        end else if (push && !halt_push) begin
            fetch_pc <= fetch_pc + PC_INC;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    assign halt_push = push && (IMemData == HALT_WORD);
    assign Halted    = (state == HALTED);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= RUN;
        end else if (Redirect) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_push) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && head.instr == HALT_WORD) state <= HALTED;
                end
                default: state <= state;
            endcase
        end
    end
`else
    assign halt_push = 1'b0;
    assign Halted    = 1'b0;
    assign state     = RUN;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (DEPTH=2).
// Halt or wrap scenario chosen by FETCH_HALT_DETECT_EN.
module tb_instruction_fetch_unit;
    logic        clock;
    logic        resetn;
    logic [15:0] IMemAddress;
    logic [15:0] IMemData;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic [15:0] IR;
    logic [15:0] IRPC;
    logic        IRValid;
    logic        IRReady;
    logic        Halted;

    logic [15:0] mem [64];
    int          n_checks;
    int          n_pass;

    instruction_fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .IMemAddress (IMemAddress),
        .IMemData    (IMemData),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .IR          (IR),
        .IRPC        (IRPC),
        .IRValid     (IRValid),
        .IRReady     (IRReady),
        .Halted      (Halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb IMemData = mem[IMemAddress[6:1]];

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        resetn     = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 16'h0000;
        IRReady    = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h710F;
        mem[1] = 16'h7207;
        mem[9] = 16'hFFFF;

        // reset values
        step();
        step();
        check("rst_valid", 16'(IRValid), 16'h0);
        check("rst_halted", 16'(Halted), 16'h0);
        check("rst_addr", IMemAddress, 16'h0000);
        check("rst_ir", IR, 16'h0000);
        check("rst_irpc", IRPC, 16'h0000);

        // streaming at one instruction per cycle
        resetn  = 1'b1;
        IRReady = 1'b1;
        step();
        check("st_valid", 16'(IRValid), 16'h1);
        check("st_pc0", IRPC, 16'h0000);
        check("st_ir0", IR, 16'h710F);
        step();
        check("st_pc1", IRPC, 16'h0002);
        check("st_ir1", IR, 16'h7207);
        step();
        check("st_pc2", IRPC, 16'h0004);
        check("st_ir2", IR, 16'h1002);
        check("st_addr", IMemAddress, 16'h0006);

        // backpressure: queue saturates, PC parks at 4
        IRReady = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("bp_addr", IMemAddress, 16'h0004);
        check("bp_valid", 16'(IRValid), 16'h1);
        check("bp_head", IRPC, 16'h0000);
        IRReady = 1'b1;
        step();
        check("bp_pc2", IRPC, 16'h0002);
        step();
        check("bp_pc4", IRPC, 16'h0004);
        check("bp_ir4", IR, 16'h1002);
        step();
        check("bp_pc6", IRPC, 16'h0006);

        // redirect while full, odd target
        IRReady    = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 16'h0021;
        step();
        Redirect = 1'b0;
        check("rd_valid0", 16'(IRValid), 16'h0);
        check("rd_addr", IMemAddress, 16'h0020);
        step();
        check("rd_valid1", 16'(IRValid), 16'h1);
        check("rd_pc", IRPC, 16'h0020);
        check("rd_ir", IR, 16'h1010);
        IRReady = 1'b1;
        step();
        check("rd_next", IRPC, 16'h0022);

`ifdef FETCH_HALT_DETECT_EN
        // halt word at 0x12
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("h_pc", IRPC, 16'h0012);
        check("h_ir", IR, 16'hFFFF);
        check("h_addr", IMemAddress, 16'h0012);
        check("h_notyet", 16'(Halted), 16'h0);
        step();
        check("h_halted", 16'(Halted), 16'h1);
        check("h_valid", 16'(IRValid), 16'h0);
        step();
        check("h_park", IMemAddress, 16'h0012);
        check("h_empty", 16'(IRValid), 16'h0);
        Redirect   = 1'b1;
        RedirectPC = 16'h0000;
        step();
        Redirect = 1'b0;
        check("h_clr", 16'(Halted), 16'h0);
        step();
        check("h_resume_v", 16'(IRValid), 16'h1);
        check("h_resume_pc", IRPC, 16'h0000);
`else
        // wrap and halt word as ordinary data
        Redirect   = 1'b1;
        RedirectPC = 16'hFFFC;
        step();
        Redirect = 1'b0;
        check("w_valid0", 16'(IRValid), 16'h0);
        step();
        check("w_pc0", IRPC, 16'hFFFC);
        check("w_ir0", IR, 16'h103E);
        step();
        check("w_pc1", IRPC, 16'hFFFE);
        step();
        check("w_pc2", IRPC, 16'h0000);
        check("w_ir2", IR, 16'h710F);
        for (int i = 0; i < 9; i++) step();
        check("w_ffff_pc", IRPC, 16'h0012);
        check("w_ffff_ir", IR, 16'hFFFF);
        check("w_halted", 16'(Halted), 16'h0);
        step();
        check("w_cont", IRPC, 16'h0014);
        check("w_cont_v", 16'(IRValid), 16'h1);
`endif

        // reset with a full queue holding the halt word
        IRReady    = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 16'h0010;
        step();
        Redirect = 1'b0;
        step();
        step();
        check("md_full", IRPC, 16'h0010);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("md_valid", 16'(IRValid), 16'h0);
        check("md_halted", 16'(Halted), 16'h0);
        check("md_addr", IMemAddress, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
